// File: rtl/obi_to_vx_dcache_bridge_if.sv
// Bus bundle for the OBI-to-VX dcache bridge: OBI slave port plus VX request/response port.
// The slave modport is the bridge's view; the master modport is the surrounding system's view.
interface obi_to_vx_dcache_bridge_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 2
);
    logic                    obi_req_i;
    logic                    obi_gnt_o;
    logic [ADDR_WIDTH-1:0]   obi_addr_i;
    logic                    obi_we_i;
    logic [DATA_WIDTH/8-1:0] obi_be_i;
    logic [DATA_WIDTH-1:0]   obi_wdata_i;
    logic                    obi_rvalid_o;
    logic [DATA_WIDTH-1:0]   obi_rdata_o;

    logic                    vx_req_valid_o;
    logic                    vx_req_rw_o;
    logic [DATA_WIDTH/8-1:0] vx_req_byteen_o;
    logic [ADDR_WIDTH-3:0]   vx_req_addr_o;
    logic [DATA_WIDTH-1:0]   vx_req_data_o;
    logic [TAG_WIDTH-1:0]    vx_req_tag_o;
    logic                    vx_req_ready_i;
    logic                    vx_rsp_valid_i;
    logic [DATA_WIDTH-1:0]   vx_rsp_data_i;
    logic [TAG_WIDTH-1:0]    vx_rsp_tag_i;
    logic                    vx_rsp_ready_o;
    logic                    err_o;

    modport slave (
        input  obi_req_i, obi_addr_i, obi_we_i, obi_be_i, obi_wdata_i,
        input  vx_req_ready_i, vx_rsp_valid_i, vx_rsp_data_i, vx_rsp_tag_i,
        output obi_gnt_o, obi_rvalid_o, obi_rdata_o,
        output vx_req_valid_o, vx_req_rw_o, vx_req_byteen_o, vx_req_addr_o,
        output vx_req_data_o, vx_req_tag_o, vx_rsp_ready_o, err_o
    );

    modport master (
        output obi_req_i, obi_addr_i, obi_we_i, obi_be_i, obi_wdata_i,
        output vx_req_ready_i, vx_rsp_valid_i, vx_rsp_data_i, vx_rsp_tag_i,
        input  obi_gnt_o, obi_rvalid_o, obi_rdata_o,
        input  vx_req_valid_o, vx_req_rw_o, vx_req_byteen_o, vx_req_addr_o,
        input  vx_req_data_o, vx_req_tag_o, vx_rsp_ready_o, err_o
    );
endinterface

// File: rtl/obi_to_vx_dcache_bridge.sv
// OBI slave to VX dcache master bridge: tags requests with a ring slot, reorders VX read
// responses back into request order and synthesises OBI responses for writes.
module obi_to_vx_dcache_bridge #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4,
    parameter int TAG_WIDTH       = $clog2(MAX_OUTSTANDING)
) (
    input logic                       clk_i,
    input logic                       rst_i,
    obi_to_vx_dcache_bridge_if.slave  bus
);
    localparam int BE_WIDTH  = DATA_WIDTH / 8;
    localparam int CNT_WIDTH = TAG_WIDTH + 1;
    localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_OUTSTANDING);

    logic [MAX_OUTSTANDING-1:0] ent_valid;
    logic [MAX_OUTSTANDING-1:0] ent_is_wr;
    logic [MAX_OUTSTANDING-1:0] ent_done;
    logic [DATA_WIDTH-1:0]      ent_data [MAX_OUTSTANDING];
    logic [TAG_WIDTH-1:0]       wr_ptr;
    logic [TAG_WIDTH-1:0]       rd_ptr;
    logic [CNT_WIDTH-1:0]       count;

    logic                       req_valid;
    logic                       req_rw;
    logic [BE_WIDTH-1:0]        req_be;
    logic [ADDR_WIDTH-3:0]      req_addr;
    logic [DATA_WIDTH-1:0]      req_data;
    logic [TAG_WIDTH-1:0]       req_tag;

    logic                       rsp_ready;
    logic                       rvalid;
    logic [DATA_WIDTH-1:0]      rdata;
    logic                       err;

    logic gnt;
    logic req_hs;
    logic rsp_hs;
    logic rsp_ok;
    logic retire;
    logic addr_lsb_unused;

    // Grant uses the registered count, so a full ring stays closed even in a retiring cycle.
    assign gnt    = bus.obi_req_i & (count < MAX_CNT) & (~req_valid | bus.vx_req_ready_i);
    assign req_hs = req_valid & bus.vx_req_ready_i;
    assign rsp_hs = bus.vx_rsp_valid_i & rsp_ready;
    assign rsp_ok = ent_valid[bus.vx_rsp_tag_i] & ~ent_is_wr[bus.vx_rsp_tag_i]
                    & ~ent_done[bus.vx_rsp_tag_i];
    assign retire = ent_valid[rd_ptr] & ent_done[rd_ptr];
    assign addr_lsb_unused = ^bus.obi_addr_i[1:0];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            req_valid <= 1'b0;
            req_rw    <= 1'b0;
            req_be    <= '0;
            req_addr  <= '0;
            req_data  <= '0;
            req_tag   <= '0;
        end else if (gnt) begin
            req_valid <= 1'b1;
            req_rw    <= bus.obi_we_i;
            req_be    <= bus.obi_be_i;
            req_addr  <= bus.obi_addr_i[ADDR_WIDTH-1:2];
            req_data  <= bus.obi_wdata_i;
            req_tag   <= wr_ptr;
        end else if (req_hs) begin
            req_valid <= 1'b0;
        end
    end

    // Allocation, write completion, read completion and retirement never collide on one slot:
    // a full ring blocks grant, and a slot only retires once its done bit is already set.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ent_valid <= '0;
            ent_is_wr <= '0;
            ent_done  <= '0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) ent_data[i] <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
        end else begin
            if (retire) begin
                ent_valid[rd_ptr] <= 1'b0;
                ent_done[rd_ptr]  <= 1'b0;
                rd_ptr            <= rd_ptr + TAG_WIDTH'(1);
            end
            if (gnt) begin
                ent_valid[wr_ptr] <= 1'b1;
                ent_is_wr[wr_ptr] <= bus.obi_we_i;
                ent_done[wr_ptr]  <= 1'b0;
                ent_data[wr_ptr]  <= '0;
                wr_ptr            <= wr_ptr + TAG_WIDTH'(1);
            end
            if (req_hs & req_rw) ent_done[req_tag] <= 1'b1;
            if (rsp_hs & rsp_ok) begin
                ent_data[bus.vx_rsp_tag_i] <= bus.vx_rsp_data_i;
                ent_done[bus.vx_rsp_tag_i] <= 1'b1;
            end
            count <= count + CNT_WIDTH'(gnt) - CNT_WIDTH'(retire);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rsp_ready <= 1'b0;
            rvalid    <= 1'b0;
            rdata     <= '0;
            err       <= 1'b0;
        end else begin
            rsp_ready <= 1'b1;
            rvalid    <= retire;
            rdata     <= (retire & ~ent_is_wr[rd_ptr]) ? ent_data[rd_ptr] : '0;
            if (rsp_hs & ~rsp_ok) err <= 1'b1;
        end
    end

    assign bus.obi_gnt_o       = gnt;
    assign bus.obi_rvalid_o    = rvalid;
    assign bus.obi_rdata_o     = rdata;
    assign bus.vx_req_valid_o  = req_valid;
    assign bus.vx_req_rw_o     = req_rw;
    assign bus.vx_req_byteen_o = req_be;
    assign bus.vx_req_addr_o   = req_addr;
    assign bus.vx_req_data_o   = req_data;
    assign bus.vx_req_tag_o    = req_tag;
    assign bus.vx_rsp_ready_o  = rsp_ready;
    assign bus.err_o           = err;
endmodule

// File: tb/tb_obi_to_vx_dcache_bridge.sv
// Self-checking bench for obi_to_vx_dcache_bridge: directed vector table, hand-written corner
// sequences and a randomized run against an in-order transaction-queue reference model.
module tb_obi_to_vx_dcache_bridge;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MO = 4;
    localparam int TW = 2;

    logic clk_i;
    logic rst_i;

    obi_to_vx_dcache_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_WIDTH(TW)) b();

    obi_to_vx_dcache_bridge #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO), .TAG_WIDTH(TW)
    ) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (b.slave)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_checks;
    int n_fail;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        b.obi_req_i      = 1'b0;
        b.obi_addr_i     = '0;
        b.obi_we_i       = 1'b0;
        b.obi_be_i       = '0;
        b.obi_wdata_i    = '0;
        b.vx_req_ready_i = 1'b0;
        b.vx_rsp_valid_i = 1'b0;
        b.vx_rsp_data_i  = '0;
        b.vx_rsp_tag_i   = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_i = 1'b1;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
    endtask

    // Directed single-transaction vectors; latencies counted from the grant cycle.
    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          rsp_at;
        logic [31:0] rsp_data;
        logic [29:0] exp_vaddr;
        logic [1:0]  exp_tag;
        int          exp_lat;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[5];

    // Reference model: in-order queue of OBI transactions not yet answered on OBI.
    typedef struct {
        logic [1:0]  tag;
        logic        we;
        logic [31:0] data;
    } txn_t;

    txn_t        oq[$];
    logic [1:0]  rq[$];
    bit          pend;
    logic [29:0] p_addr;
    logic [1:0]  p_tag;
    logic        p_we;
    logic [3:0]  p_be;
    logic [31:0] p_wdata;
    int          alloc_idx;

    task automatic rand_cycle(input bit drain);
        bit          send;
        bit          exp_gnt;
        int          idx;
        logic [1:0]  stag;
        logic [31:0] sdata;
        txn_t        t;
        send  = 1'b0;
        stag  = '0;
        sdata = '0;
        @(negedge clk_i);
        b.obi_req_i      = drain ? 1'b0 : ($urandom_range(0, 3) != 0);
        b.obi_we_i       = 1'($urandom_range(0, 1));
        b.obi_addr_i     = $urandom;
        b.obi_be_i       = 4'($urandom_range(0, 15));
        b.obi_wdata_i    = $urandom;
        b.vx_req_ready_i = drain ? 1'b1 : ($urandom_range(0, 3) != 0);
        if (rq.size() != 0 && (drain || $urandom_range(0, 2) == 0)) begin
            send  = 1'b1;
            idx   = $urandom_range(0, rq.size() - 1);
            stag  = rq[idx];
            rq.delete(idx);
            sdata = $urandom;
        end
        b.vx_rsp_valid_i = send;
        b.vx_rsp_tag_i   = send ? stag : 2'($urandom_range(0, 3));
        b.vx_rsp_data_i  = send ? sdata : $urandom;
        #1;
        if (b.obi_rvalid_o) begin
            if (oq.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rand_rvalid: got rvalid=1 expected no outstanding response");
            end else begin
                t = oq.pop_front();
                check("rand_rdata", 64'(b.obi_rdata_o), 64'(t.we ? 32'h0 : t.data));
            end
        end
        check("rand_vx_valid", 64'(b.vx_req_valid_o), 64'(pend));
        if (pend) begin
            check("rand_vx_fields",
                  64'({b.vx_req_addr_o, b.vx_req_tag_o, b.vx_req_rw_o, b.vx_req_byteen_o}),
                  64'({p_addr, p_tag, p_we, p_be}));
            check("rand_vx_data", 64'(b.vx_req_data_o), 64'(p_wdata));
        end
        exp_gnt = b.obi_req_i && (oq.size() < MO) && (!pend || b.vx_req_ready_i);
        check("rand_gnt", 64'(b.obi_gnt_o), 64'(exp_gnt));
        check("rand_err", 64'(b.err_o), 64'(0));
        if (pend && b.vx_req_ready_i) begin
            if (!p_we) rq.push_back(p_tag);
            pend = 1'b0;
        end
        if (send) begin
            foreach (oq[i]) if (oq[i].tag == stag) oq[i].data = sdata;
        end
        if (exp_gnt) begin
            oq.push_back('{tag: 2'(alloc_idx % MO), we: b.obi_we_i, data: 32'h0});
            pend    = 1'b1;
            p_addr  = b.obi_addr_i[31:2];
            p_tag   = 2'(alloc_idx % MO);
            p_we    = b.obi_we_i;
            p_be    = b.obi_be_i;
            p_wdata = b.obi_wdata_i;
            alloc_idx++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected test completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         nrv;
        int         grants;
        int         rv_cyc;
        int         g_cyc;
        logic [1:0]  tags[$];
        logic [31:0] got[$];
        logic [31:0] exp_ooo[3];

        n_checks = 0;
        n_fail   = 0;

        vecs[0] = '{1'b0, 32'h0000_1000, 4'hF, 32'h0,         4, 32'hDEAD_BEEF, 30'h400,       2'd0, 6, 32'hDEAD_BEEF};
        vecs[1] = '{1'b1, 32'h0000_2004, 4'h3, 32'h0000_1234, 0, 32'h0,         30'h801,       2'd1, 3, 32'h0};
        vecs[2] = '{1'b0, 32'hFFFF_FFFC, 4'hF, 32'h0,         2, 32'h0000_5A5A, 30'h3FFF_FFFF, 2'd2, 4, 32'h0000_5A5A};
        vecs[3] = '{1'b1, 32'h0000_0000, 4'hF, 32'hFFFF_FFFF, 0, 32'h0,         30'h0,         2'd3, 3, 32'h0};
        vecs[4] = '{1'b0, 32'h0000_0ABF, 4'h1, 32'h0000_00AA, 7, 32'h1357_9BDF, 30'h2AF,       2'd0, 9, 32'h1357_9BDF};

        // Reset state
        idle_inputs();
        rst_i = 1'b1;
        #1;
        check("rst_gnt", 64'(b.obi_gnt_o), 64'(0));
        check("rst_vx_valid", 64'(b.vx_req_valid_o), 64'(0));
        check("rst_rvalid", 64'(b.obi_rvalid_o), 64'(0));
        check("rst_rdata", 64'(b.obi_rdata_o), 64'(0));
        check("rst_err", 64'(b.err_o), 64'(0));
        check("rst_rsp_ready", 64'(b.vx_rsp_ready_o), 64'(0));
        check("rst_vx_fields", 64'({b.vx_req_addr_o, b.vx_req_tag_o, b.vx_req_rw_o, b.vx_req_byteen_o}), 64'(0));
        do_reset();
        #1;
        check("rsp_ready_after_rst", 64'(b.vx_rsp_ready_o), 64'(1));

        // Vector table
        for (int v = 0; v < 5; v++) begin
            nrv = 0;
            @(negedge clk_i);
            b.obi_req_i      = 1'b1;
            b.obi_we_i       = vecs[v].we;
            b.obi_addr_i     = vecs[v].addr;
            b.obi_be_i       = vecs[v].be;
            b.obi_wdata_i    = vecs[v].wdata;
            b.vx_req_ready_i = 1'b1;
            #1;
            check($sformatf("vec%0d_gnt", v), 64'(b.obi_gnt_o), 64'(1));
            for (int c = 1; c <= 12; c++) begin
                @(negedge clk_i);
                b.obi_req_i      = 1'b0;
                b.vx_rsp_valid_i = (!vecs[v].we && c == vecs[v].rsp_at);
                b.vx_rsp_tag_i   = vecs[v].exp_tag;
                b.vx_rsp_data_i  = vecs[v].rsp_data;
                #1;
                if (c == 1) begin
                    check($sformatf("vec%0d_vx_valid", v), 64'(b.vx_req_valid_o), 64'(1));
                    check($sformatf("vec%0d_vx_addr", v), 64'(b.vx_req_addr_o), 64'(vecs[v].exp_vaddr));
                    check($sformatf("vec%0d_vx_tag", v), 64'(b.vx_req_tag_o), 64'(vecs[v].exp_tag));
                    check($sformatf("vec%0d_vx_rw_be", v), 64'({b.vx_req_rw_o, b.vx_req_byteen_o}),
                          64'({vecs[v].we, vecs[v].be}));
                    check($sformatf("vec%0d_vx_data", v), 64'(b.vx_req_data_o), 64'(vecs[v].wdata));
                end
                if (c == 2) check($sformatf("vec%0d_vx_drop", v), 64'(b.vx_req_valid_o), 64'(0));
                if (b.obi_rvalid_o) begin
                    nrv++;
                    check($sformatf("vec%0d_latency", v), 64'(c), 64'(vecs[v].exp_lat));
                    check($sformatf("vec%0d_rdata", v), 64'(b.obi_rdata_o), 64'(vecs[v].exp_rdata));
                end
            end
            b.vx_rsp_valid_i = 1'b0;
            check($sformatf("vec%0d_rvalid_count", v), 64'(nrv), 64'(1));
        end
        check("vec_err", 64'(b.err_o), 64'(0));

        // Out-of-order responses returned in request order
        do_reset();
        exp_ooo[0] = 32'hA;
        exp_ooo[1] = 32'hB;
        exp_ooo[2] = 32'hC;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            b.obi_req_i      = 1'b1;
            b.obi_we_i       = 1'b0;
            b.obi_addr_i     = 32'h100 + 32'(4 * i);
            b.vx_req_ready_i = 1'b1;
            #1;
            check($sformatf("ooo_gnt%0d", i), 64'(b.obi_gnt_o), 64'(1));
        end
        @(negedge clk_i);
        b.obi_req_i = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk_i);
            b.vx_rsp_valid_i = (c < 3);
            b.vx_rsp_tag_i   = (c == 0) ? 2'd2 : (c == 1) ? 2'd0 : 2'd1;
            b.vx_rsp_data_i  = (c == 0) ? 32'hC : (c == 1) ? 32'hA : 32'hB;
            #1;
            if (b.obi_rvalid_o) got.push_back(b.obi_rdata_o);
        end
        b.vx_rsp_valid_i = 1'b0;
        check("ooo_count", 64'(got.size()), 64'(3));
        for (int i = 0; i < got.size() && i < 3; i++)
            check($sformatf("ooo_data%0d", i), 64'(got[i]), 64'(exp_ooo[i]));
        check("ooo_err", 64'(b.err_o), 64'(0));

        // Full ring and VX backpressure
        do_reset();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_i);
            b.obi_req_i      = 1'b1;
            b.obi_we_i       = 1'b0;
            b.obi_addr_i     = 32'h200 + 32'(4 * c);
            b.vx_req_ready_i = 1'b0;
            #1;
            check($sformatf("bp_gnt%0d", c), 64'(b.obi_gnt_o), 64'(c == 0));
        end
        grants = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk_i);
            b.vx_req_ready_i = 1'b1;
            #1;
            if (b.vx_req_valid_o) tags.push_back(b.vx_req_tag_o);
            if (b.obi_gnt_o) grants++;
        end
        check("full_grants", 64'(grants), 64'(3));
        check("full_tag_count", 64'(tags.size()), 64'(4));
        for (int i = 0; i < tags.size() && i < 4; i++)
            check($sformatf("full_tag%0d", i), 64'(tags[i]), 64'(i));
        rv_cyc = -1;
        g_cyc  = -1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk_i);
            b.obi_req_i      = (g_cyc < 0);
            b.vx_rsp_valid_i = (c == 0);
            b.vx_rsp_tag_i   = 2'd0;
            b.vx_rsp_data_i  = 32'h77;
            #1;
            if (g_cyc >= 0 && c == g_cyc + 1) begin
                check("wrap_vx_valid", 64'(b.vx_req_valid_o), 64'(1));
                check("wrap_vx_tag", 64'(b.vx_req_tag_o), 64'(0));
            end
            if (b.obi_rvalid_o && rv_cyc < 0) begin
                rv_cyc = c;
                check("full_rdata", 64'(b.obi_rdata_o), 64'(32'h77));
            end
            if (b.obi_gnt_o && g_cyc < 0) g_cyc = c;
        end
        check("full_retire_cycle", 64'(rv_cyc), 64'(2));
        check("full_regrant_cycle", 64'(g_cyc), 64'(2));

        // Spurious response
        do_reset();
        @(negedge clk_i);
        b.vx_rsp_valid_i = 1'b1;
        b.vx_rsp_tag_i   = 2'd1;
        b.vx_rsp_data_i  = 32'h99;
        #1;
        check("spur_err_before", 64'(b.err_o), 64'(0));
        nrv = 0;
        @(negedge clk_i);
        b.vx_rsp_valid_i = 1'b0;
        #1;
        check("spur_err_rise", 64'(b.err_o), 64'(1));
        repeat (4) begin
            @(negedge clk_i);
            #1;
            if (b.obi_rvalid_o) nrv++;
        end
        check("spur_err_sticky", 64'(b.err_o), 64'(1));
        check("spur_no_rvalid", 64'(nrv), 64'(0));

        // Reset with two reads in flight
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_i);
            b.obi_req_i      = 1'b1;
            b.obi_we_i       = 1'b0;
            b.obi_be_i       = 4'hF;
            b.obi_addr_i     = 32'h300 + 32'(4 * i);
            b.obi_wdata_i    = 32'h5555_0000;
            b.vx_req_ready_i = 1'b1;
            #1;
            check($sformatf("mid_gnt%0d", i), 64'(b.obi_gnt_o), 64'(1));
        end
        @(negedge clk_i);
        b.obi_req_i = 1'b0;
        #1;
        rst_i = 1'b1;
        #1;
        check("mid_rst_vx_valid", 64'(b.vx_req_valid_o), 64'(0));
        check("mid_rst_vx_fields", 64'({b.vx_req_addr_o, b.vx_req_tag_o, b.vx_req_rw_o, b.vx_req_byteen_o}), 64'(0));
        check("mid_rst_vx_data", 64'(b.vx_req_data_o), 64'(0));
        check("mid_rst_obi", 64'({b.obi_gnt_o, b.obi_rvalid_o, b.obi_rdata_o}), 64'(0));
        check("mid_rst_err", 64'(b.err_o), 64'(0));
        check("mid_rst_rsp_ready", 64'(b.vx_rsp_ready_o), 64'(0));
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        b.vx_rsp_valid_i = 1'b1;
        b.vx_rsp_tag_i   = 2'd0;
        b.vx_rsp_data_i  = 32'h1111;
        #1;
        @(negedge clk_i);
        b.vx_rsp_valid_i = 1'b0;
        #1;
        check("mid_stale_err", 64'(b.err_o), 64'(1));
        @(negedge clk_i);
        b.obi_req_i  = 1'b1;
        b.obi_addr_i = 32'h400;
        #1;
        check("mid_new_gnt", 64'(b.obi_gnt_o), 64'(1));
        @(negedge clk_i);
        b.obi_req_i = 1'b0;
        #1;
        check("mid_new_vx_valid", 64'(b.vx_req_valid_o), 64'(1));
        check("mid_new_tag", 64'(b.vx_req_tag_o), 64'(0));
        check("mid_new_addr", 64'(b.vx_req_addr_o), 64'(30'h100));

        // Randomized run against the reference model
        do_reset();
        oq.delete();
        rq.delete();
        pend      = 1'b0;
        alloc_idx = 0;
        for (int i = 0; i < 1500; i++) rand_cycle(1'b0);
        for (int i = 0; i < 200 && (oq.size() != 0 || pend); i++) rand_cycle(1'b1);
        check("rand_drain_outstanding", 64'(oq.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
